// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronises and debounces the start/stop and reset pushbuttons,
//            producing debounced levels and one-cycle press pulses.
// Revision : 1.0
// ============================================================================
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_ss_raw,
   input  logic btn_rst_raw,
   output logic start_stop,
   output logic reset_btn,
   output logic ss_level,
   output logic rst_level
);

   localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ACCEPT = CNT_W'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   logic [1:0] w_raw;
   logic [1:0] w_press_acc;
   logic [1:0] w_level;
   logic       start_stop_q;
   logic       start_stop_d;
   logic       reset_btn_q;
   logic       reset_btn_d;

   assign w_raw = {btn_rst_raw, btn_ss_raw};

   // Channel 0 = start/stop, channel 1 = reset button.
   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic             sync1_q;
      logic             sync2_q;
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;
      state_t           state_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            state_q <= RELEASED;
         end else begin
            sync1_q <= w_raw[g];
            sync2_q <= sync1_q;
            case (state_q)
               RELEASED: begin
                  if (sync2_q) begin
                     state_q <= PRESS_CHK;
                     cnt_q   <= '0;
                  end
               end
               PRESS_CHK: begin
                  if (!sync2_q) begin
                     state_q <= RELEASED;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_ACCEPT) begin
                     // Entry cycle counts as the first stable sample.
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               PRESSED: begin
                  if (!sync2_q) begin
                     state_q <= RELEASE_CHK;
                     cnt_q   <= '0;
                  end
               end
               RELEASE_CHK: begin
                  if (sync2_q) begin
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_ACCEPT) begin
                     state_q <= RELEASED;
                     cnt_q   <= '0;
                     level_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign w_press_acc[g] = (state_q == PRESS_CHK) && sync2_q && (cnt_q == CNT_ACCEPT);
      assign w_level[g]     = level_q;
   end

   // Reset press wins; start/stop is blocked while the reset button is down.
   always_comb begin
      reset_btn_d  = w_press_acc[1];
      start_stop_d = w_press_acc[0] && !w_press_acc[1] && !w_level[1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_stop_q <= 1'b0;
         reset_btn_q  <= 1'b0;
      end else begin
         start_stop_q <= start_stop_d;
         reset_btn_q  <= reset_btn_d;
      end
   end

   assign start_stop = start_stop_q;
   assign reset_btn  = reset_btn_q;
   assign ss_level   = w_level[0];
   assign rst_level  = w_level[1];

endmodule
`default_nettype wire
